// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory request path: size encodings,
// address-phase FSM states and the in-flight request limit.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    ST_IDLE,
    ST_ADDR
  } state_e;

  localparam int unsigned MAX_INFLIGHT = 2;

endpackage

// File: rtl/dsram_rsp_fifo.sv
// Two-entry response FIFO between the data SRAM and MEM. A synchronous clear
// takes priority over push/pop; outputs come straight from registers.
module dsram_rsp_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = i_push && (r_count != 2'd2);
  assign w_pop_ok  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop_ok) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/dsram_req_ctrl.sv
// Data-SRAM request controller: issues EX loads/stores with at most two in
// flight, queues responses for MEM and drops responses cancelled by flush.
// Optional statistics counters are enabled with DSRAM_CTRL_STAT_EN.
module dsram_req_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_req_valid,
  output logic                ex_req_ready,
  input  logic                ex_req_wr,
  input  logic [1:0]          ex_req_size,
  input  logic [ADDR_W-1:0]   ex_req_addr,
  input  logic [DATA_W/8-1:0] ex_req_wstrb,
  input  logic [DATA_W-1:0]   ex_req_wdata,
  input  logic                flush,
  output logic                mem_rsp_valid,
  input  logic                mem_rsp_ready,
  output logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W/8-1:0] data_sram_wstrb,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [DATA_W-1:0]   data_sram_rdata
`ifdef DSRAM_CTRL_STAT_EN
  ,
  output logic [31:0]         stat_req_cnt,
  output logic [31:0]         stat_stall_cnt
`endif
);

  localparam logic [2:0] INFL_LIM = 3'(MAX_INFLIGHT);

  state_e      r_state;
  logic [1:0]  r_outstanding;
  logic [1:0]  r_discard;
  logic [1:0]  r_order;
  logic [1:0]  w_fifo_cnt;
  logic [1:0]  w_out_dec;
  logic [1:0]  w_ord_nxt;
  logic [2:0]  w_inflight;
  logic        w_hs;
  logic        w_aok;
  logic        w_dok;
  logic        w_push;
  logic        w_pop;
  logic [DATA_W-1:0] w_push_data;

  assign data_sram_req = (r_state == ST_ADDR);
  assign w_inflight    = {1'b0, r_outstanding} + {2'b00, data_sram_req};
  // FIFO room is reserved at acceptance time, so a push can never overflow.
  assign ex_req_ready  = (r_state == ST_IDLE) && !flush
                         && ((w_inflight + {1'b0, w_fifo_cnt}) < INFL_LIM);
  assign w_hs          = ex_req_valid && ex_req_ready;
  assign w_aok         = data_sram_req && data_sram_addr_ok;
  assign w_dok         = data_sram_data_ok && (r_outstanding != 2'd0);
  assign w_out_dec     = r_outstanding - {1'b0, w_dok};
  assign w_push        = w_dok && (r_discard == 2'd0);
  assign w_pop         = mem_rsp_valid && mem_rsp_ready;
  assign w_push_data   = r_order[0] ? '0 : data_sram_rdata;

  // r_order[0] holds the store flag of the oldest outstanding request.
  always_comb begin
    w_ord_nxt = r_order;
    if (w_dok) begin
      w_ord_nxt = {1'b0, r_order[1]};
    end
    if (w_aok) begin
      w_ord_nxt[w_out_dec[0]] = data_sram_wr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= ST_IDLE;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= '0;
      data_sram_addr  <= '0;
      data_sram_wstrb <= '0;
      data_sram_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            data_sram_wr    <= ex_req_wr;
            data_sram_size  <= ex_req_size;
            data_sram_addr  <= ex_req_addr;
            data_sram_wstrb <= ex_req_wstrb;
            data_sram_wdata <= ex_req_wdata;
            r_state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (data_sram_addr_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outstanding <= '0;
      r_order       <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_dec + {1'b0, w_aok};
      r_order       <= w_ord_nxt;
      // Everything still in flight after this cycle belongs to cancelled work.
      if (flush) begin
        r_discard <= w_inflight[1:0] - {1'b0, w_dok};
      end else if (w_dok && (r_discard != 2'd0)) begin
        r_discard <= r_discard - 2'd1;
      end
    end
  end

  dsram_rsp_fifo #(
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_valid (mem_rsp_valid),
    .o_rdata (mem_rsp_rdata),
    .o_count (w_fifo_cnt)
  );

`ifdef DSRAM_CTRL_STAT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_req_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (w_aok) begin
        stat_req_cnt <= stat_req_cnt + 32'd1;
      end
      if (ex_req_valid && !ex_req_ready) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
